// File: rtl/alu_seq_if.sv
// Request/response handshake bundle between the ALU sequencer and its client.
// The client drives operations and result backpressure; the sequencer answers.
interface alu_seq_if #(parameter int W = 20);
    logic         req_valid;
    logic         req_ready;
    logic [3:0]   req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         req_half;
    logic [4:0]   req_shamt;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;

    modport master (
        output req_valid, req_op, req_a, req_b, req_half, req_shamt, rsp_ready,
        input  req_ready, rsp_valid, rsp_result
    );
    modport slave (
        input  req_valid, req_op, req_a, req_b, req_half, req_shamt, rsp_ready,
        output req_ready, rsp_valid, rsp_result
    );
endinterface

// File: rtl/alu_sequencer.sv
// Single-issue ALU sequencer: one-cycle logic/arithmetic, iterated 1-bit shifts
// and rotates, full/half-word masking, and the {sign, zero, carry} status register.
module alu_sequencer #(parameter int W = 20) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus,
    input  logic       sr_wr,
    input  logic [2:0] sr_wdata,
    input  logic       sr_xor,
    output logic [2:0] status,
    output logic       busy
);
    localparam int H = W / 2;

    localparam logic [3:0] OP_NOP = 4'd0,  OP_NOT = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3,
                           OP_XOR = 4'd4,  OP_SHL = 4'd5,  OP_SHR = 4'd6,  OP_ROL = 4'd7,
                           OP_ROR = 4'd8,  OP_INC = 4'd9,  OP_DEC = 4'd10, OP_ADD = 4'd11,
                           OP_ADC = 4'd12, OP_SUB = 4'd13, OP_SBB = 4'd14, OP_CMP = 4'd15;

    typedef enum logic [1:0] {IDLE, EXEC, ITER, DONE} state_t;

    localparam logic [W-1:0] HMASK = {{(W-H){1'b0}}, {H{1'b1}}};

    state_t       state;
    logic [3:0]   op_q;
    logic [W-1:0] a_q, b_q, result;
    logic         half_q, cin_q;
    logic [4:0]   cnt;

    logic [W-1:0] mask, top_bit;
    logic         msb;
    logic [W:0]   ext;
    logic [W-1:0] ex_out, ex_flag;
    logic         ex_c;
    logic [W-1:0] st_val;
    logic         st_c;
    logic         is_shift;

    assign mask     = half_q ? HMASK : {W{1'b1}};
    assign top_bit  = half_q ? {{(W-H){1'b0}}, 1'b1, {(H-1){1'b0}}} : {1'b1, {(W-1){1'b0}}};
    assign msb      = half_q ? a_q[H-1] : a_q[W-1];
    assign is_shift = (op_q == OP_SHL) || (op_q == OP_SHR) || (op_q == OP_ROL) || (op_q == OP_ROR);

    function automatic logic [2:0] flags_of(input logic [W-1:0] v, input logic h, input logic c);
        return {(h ? v[H-1] : v[W-1]), (v == '0), c};
    endfunction

    // Operands are pre-masked in half mode, so bit H (or W) of the extended
    // sum/difference is exactly the carry/borrow at the active width.
    always_comb begin
        ext     = '0;
        ex_out  = '0;
        ex_flag = '0;
        ex_c    = 1'b0;
        case (op_q)
            OP_NOT: ex_out = ~a_q;
            OP_AND: ex_out = a_q & b_q;
            OP_OR:  ex_out = a_q | b_q;
            OP_XOR: ex_out = a_q ^ b_q;
            OP_INC: ext = {1'b0, a_q} + {{W{1'b0}}, 1'b1};
            OP_DEC: ext = {1'b0, a_q} - {{W{1'b0}}, 1'b1};
            OP_ADD: ext = {1'b0, a_q} + {1'b0, b_q};
            OP_ADC: ext = {1'b0, a_q} + {1'b0, b_q} + {{W{1'b0}}, cin_q};
            OP_SUB, OP_CMP: ext = {1'b0, a_q} - {1'b0, b_q};
            OP_SBB: ext = {1'b0, a_q} - {1'b0, b_q} - {{W{1'b0}}, cin_q};
            default: ;
        endcase
        if (op_q >= OP_INC) begin
            ex_out = ext[W-1:0];
            ex_c   = half_q ? ext[H] : ext[W];
        end
        ex_out  = ex_out & mask;
        ex_flag = ex_out;
        if (op_q == OP_CMP) ex_out = a_q;
    end

    always_comb begin
        st_val = '0;
        st_c   = 1'b0;
        case (op_q)
            OP_SHL: begin st_val = (a_q << 1) & mask;         st_c = msb;    end
            OP_SHR: begin st_val = a_q >> 1;                  st_c = a_q[0]; end
            OP_ROL: begin st_val = ((a_q << 1) & mask) | {{(W-1){1'b0}}, msb}; st_c = msb; end
            OP_ROR: begin st_val = (a_q >> 1) | (a_q[0] ? top_bit : '0);       st_c = a_q[0]; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= OP_NOP;
            a_q    <= '0;
            b_q    <= '0;
            half_q <= 1'b0;
            cin_q  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            status <= '0;
        end else begin
            if (sr_wr)       status <= sr_wdata;
            else if (sr_xor) status <= status ^ sr_wdata;
            // Flag updates below are later in the block and win over sr writes.
            case (state)
                IDLE: if (bus.req_valid) begin
                    op_q   <= bus.req_op;
                    a_q    <= bus.req_half ? (bus.req_a & HMASK) : bus.req_a;
                    b_q    <= bus.req_half ? (bus.req_b & HMASK) : bus.req_b;
                    half_q <= bus.req_half;
                    cnt    <= bus.req_shamt;
                    cin_q  <= status[0];
                    state  <= EXEC;
                end
                EXEC: begin
                    if (is_shift) begin
                        if (cnt == '0) begin
                            result <= a_q;
                            status <= flags_of(a_q, half_q, 1'b0);
                            state  <= DONE;
                        end else begin
                            state  <= ITER;
                        end
                    end else begin
                        result <= ex_out;
                        if (op_q != OP_NOP) status <= flags_of(ex_flag, half_q, ex_c);
                        state  <= DONE;
                    end
                end
                ITER: begin
                    a_q <= st_val;
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        result <= st_val;
                        status <= flags_of(st_val, half_q, st_c);
                        state  <= DONE;
                    end
                end
                DONE: if (bus.rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.rsp_valid  = (state == DONE);
    assign bus.rsp_result = result;
    assign busy           = (state != IDLE);
endmodule
